clint_timer: RTL and testbench

Machine-timer controller for the RudolV core: owns the 64-bit `mtime`/`mtimecmp` pair and drives `irq_timer` into `Pipeline`. It sits on the core's 32-bit data bus beside the memory and UART windows. It decodes its window, serves reads with the bus's one-cycle latency, and sequences the two-word `mtimecmp` update so that no spurious interrupt fires between the low and high writes.

---
 rtl/clint_pkg.sv | 30 +++
 rtl/clint_tick.sv | 27 ++
 rtl/clint_timer.sv | 124 ++++++++++++
 tb/tb_clint_timer.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clint_pkg.sv
// Shared constants, state encoding and register-offset decode for the machine-timer block.
package clint_pkg;

  localparam logic [15:0] CLINT_MTIMECMP_LO = 16'h4000;
  localparam logic [15:0] CLINT_MTIMECMP_HI = 16'h4004;
  localparam logic [15:0] CLINT_MTIME_LO    = 16'hbff8;
  localparam logic [15:0] CLINT_MTIME_HI    = 16'hbffc;

  typedef enum logic {
    CLINT_IDLE    = 1'b0,
    CLINT_LO_PEND = 1'b1
  } clint_state_e;

  typedef struct packed {
    logic cmp_lo;
    logic cmp_hi;
    logic time_lo;
    logic time_hi;
  } clint_sel_t;

  function automatic clint_sel_t clint_decode(input logic [15:0] offset);
    clint_sel_t sel;
    sel.cmp_lo  = (offset == CLINT_MTIMECMP_LO);
    sel.cmp_hi  = (offset == CLINT_MTIMECMP_HI);
    sel.time_lo = (offset == CLINT_MTIME_LO);
    sel.time_hi = (offset == CLINT_MTIME_HI);
    return sel;
  endfunction

endpackage

// File: rtl/clint_tick.sv
// Free-running prescaler: pulses tick once every PRESCALE clock cycles.
module clint_tick #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk,
  input  logic rstn,
  output logic tick
);

  localparam int unsigned W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [W-1:0] count_reg;

  // With PRESCALE=1 the count is pinned at 0, so tick stays high every cycle.
  assign tick = (count_reg == W'(PRESCALE - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_reg <= '0;
    end else if (tick) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + W'(1);
    end
  end

endmodule

// File: rtl/clint_timer.sv
// Machine-timer controller: 64-bit mtime/mtimecmp on a 32-bit bus with a level timer interrupt.
module clint_timer
  import clint_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h4400_0000,
  parameter int unsigned PRESCALE  = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        mem_valid,
  input  logic        mem_write,
  input  logic [3:0]  mem_wmask,
  input  logic [31:0] mem_wdata,
  input  logic [31:0] mem_addr,
  output logic [31:0] rdata,
  output logic        rsel,
  output logic        irq_timer
);

  logic         hit;
  logic         wr_en;
  logic         rd_en;
  clint_sel_t   sel;
  logic         tick;
  logic [63:0]  mtime_reg, mtime_next;
  logic [63:0]  mtimecmp_reg, mtimecmp_next;
  clint_state_e state_reg, state_next;
  logic         cmp_armed;
  logic         irq_reg;
  logic [31:0]  rdata_reg, rdata_next;
  logic         rsel_reg;

  assign hit   = (mem_addr[31:16] == BASE_ADDR[31:16]);
  assign sel   = clint_decode(mem_addr[15:0]);
  assign wr_en = mem_valid && mem_write && hit && (mem_wmask == 4'b1111);
  assign rd_en = mem_valid && !mem_write && hit;

  clint_tick #(
    .PRESCALE(PRESCALE)
  ) u_tick (
    .clk (clk),
    .rstn(rstn),
    .tick(tick)
  );

  // A write to either mtime half wins over the tick, so no carry leaks into the other half.
  always_comb begin
    mtime_next = mtime_reg;
    if (wr_en && sel.time_lo) begin
      mtime_next[31:0] = mem_wdata;
    end else if (wr_en && sel.time_hi) begin
      mtime_next[63:32] = mem_wdata;
    end else if (tick) begin
      mtime_next = mtime_reg + 64'd1;
    end
  end

  always_comb begin
    mtimecmp_next = mtimecmp_reg;
    if (wr_en && sel.cmp_lo) begin
      mtimecmp_next[31:0] = mem_wdata;
    end else if (wr_en && sel.cmp_hi) begin
      mtimecmp_next[63:32] = mem_wdata;
    end
  end

  always_comb begin
    rdata_next = 32'd0;
    if (rd_en) begin
      if (sel.cmp_lo)       rdata_next = mtimecmp_reg[31:0];
      else if (sel.cmp_hi)  rdata_next = mtimecmp_reg[63:32];
      else if (sel.time_lo) rdata_next = mtime_reg[31:0];
      else if (sel.time_hi) rdata_next = mtime_reg[63:32];
    end
  end

  // Compare is masked between the low and high halves of a mtimecmp update.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= CLINT_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (wr_en && sel.cmp_hi) begin
      state_next = CLINT_IDLE;
    end else if (wr_en && sel.cmp_lo) begin
      state_next = CLINT_LO_PEND;
    end
  end

  always_comb begin
    cmp_armed = 1'b0;
    unique case (state_reg)
      CLINT_IDLE:    cmp_armed = 1'b1;
      CLINT_LO_PEND: cmp_armed = 1'b0;
      default:       cmp_armed = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mtime_reg    <= 64'd0;
      mtimecmp_reg <= 64'hFFFF_FFFF_FFFF_FFFF;
      irq_reg      <= 1'b0;
      rdata_reg    <= 32'd0;
      rsel_reg     <= 1'b0;
    end else begin
      mtime_reg    <= mtime_next;
      mtimecmp_reg <= mtimecmp_next;
      irq_reg      <= (mtime_reg >= mtimecmp_reg) && cmp_armed;
      rdata_reg    <= rdata_next;
      rsel_reg     <= rd_en;
    end
  end

  assign rdata     = rdata_reg;
  assign rsel      = rsel_reg;
  assign irq_timer = irq_reg;

endmodule

// File: tb/tb_clint_timer.sv
// Scoreboard bench for clint_timer: PRESCALE=1 and PRESCALE=4 instances on a shared bus.
module tb_clint_timer;

  localparam logic [31:0] BASE = 32'h4400_0000;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        mem_valid1 = 1'b0;
  logic        mem_valid4 = 1'b0;
  logic        mem_write = 1'b0;
  logic [3:0]  mem_wmask = 4'h0;
  logic [31:0] mem_wdata = 32'h0;
  logic [31:0] mem_addr = 32'h0;
  logic [31:0] rdata1, rdata4;
  logic        rsel1, rsel4, irq1, irq4;

  always #5 clk = ~clk;

  clint_timer #(.BASE_ADDR(BASE), .PRESCALE(1)) dut1 (
    .clk(clk), .rstn(rstn), .mem_valid(mem_valid1), .mem_write(mem_write),
    .mem_wmask(mem_wmask), .mem_wdata(mem_wdata), .mem_addr(mem_addr),
    .rdata(rdata1), .rsel(rsel1), .irq_timer(irq1)
  );

  clint_timer #(.BASE_ADDR(BASE), .PRESCALE(4)) dut4 (
    .clk(clk), .rstn(rstn), .mem_valid(mem_valid4), .mem_write(mem_write),
    .mem_wmask(mem_wmask), .mem_wdata(mem_wdata), .mem_addr(mem_addr),
    .rdata(rdata4), .rsel(rsel4), .irq_timer(irq4)
  );

  typedef struct {
    string       name;
    logic        rsel;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    int    at;
    int    dut;
    string name;
    logic  val;
  } irq_t;

  exp_t q1[$];
  exp_t q4[$];
  irq_t qi[$];

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   edge_cnt = 0;
  bit   finish_req = 1'b0;
  logic iss1 = 1'b0;
  logic iss4 = 1'b0;
  exp_t me;
  irq_t mi;

  always @(posedge clk) cyc <= cyc + 1;

  // Edges since reset release, and which instance had a read in flight.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      edge_cnt <= 0;
      iss1     <= 1'b0;
      iss4     <= 1'b0;
    end else begin
      edge_cnt <= edge_cnt + 1;
      iss1     <= mem_valid1 && !mem_write;
      iss4     <= mem_valid4 && !mem_write;
    end
  end

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic void chk_rd(input exp_t e, input logic rs, input logic [31:0] d);
    chk({e.name, "_rsel"}, 64'(rs), 64'(e.rsel));
    if (e.rsel) chk({e.name, "_rdata"}, 64'(d), 64'(e.data));
  endfunction

  // Monitor: pops read expectations when a response is due, and scheduled irq checks.
  always @(negedge clk or negedge rstn) begin
    #1;
    if (!rstn) begin
      chk("rst_irq1", 64'(irq1), 64'd0);
      chk("rst_rsel1", 64'(rsel1), 64'd0);
      chk("rst_rdata1", 64'(rdata1), 64'd0);
      chk("rst_irq4", 64'(irq4), 64'd0);
      chk("rst_rsel4", 64'(rsel4), 64'd0);
      chk("rst_rdata4", 64'(rdata4), 64'd0);
    end else begin
      if (iss1) begin
        if (q1.size() == 0) begin
          chk("rd1_unexpected", 64'd1, 64'd0);
        end else begin
          me = q1.pop_front();
          chk_rd(me, rsel1, rdata1);
        end
      end else begin
        chk("idle_rsel1", 64'(rsel1), 64'd0);
      end
      if (iss4) begin
        if (q4.size() == 0) begin
          chk("rd4_unexpected", 64'd1, 64'd0);
        end else begin
          me = q4.pop_front();
          chk_rd(me, rsel4, rdata4);
        end
      end else begin
        chk("idle_rsel4", 64'(rsel4), 64'd0);
      end
      while (qi.size() > 0 && qi[0].at <= cyc) begin
        mi = qi.pop_front();
        chk(mi.name, 64'((mi.dut == 1) ? irq1 : irq4), 64'(mi.val));
      end
    end
    if (finish_req) begin
      chk("q1_drained", 64'(q1.size()), 64'd0);
      chk("q4_drained", 64'(q4.size()), 64'd0);
      chk("qi_drained", 64'(qi.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
    if (cyc > 20000) begin
      bad++;
      $display("FAIL watchdog: cycle=%0d limit=20000", cyc);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  end

  task automatic do_req(input int dut, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] wmask);
    @(negedge clk);
    mem_valid1 = (dut == 1);
    mem_valid4 = (dut == 4);
    mem_write  = wr;
    mem_addr   = addr;
    mem_wdata  = wdata;
    mem_wmask  = wmask;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      mem_valid1 = 1'b0;
      mem_valid4 = 1'b0;
      mem_write  = 1'b0;
    end
  endtask

  task automatic push_rd(input int dut, input string name, input logic rs, input logic [31:0] d);
    exp_t e;
    e.name = name;
    e.rsel = rs;
    e.data = d;
    if (dut == 1) q1.push_back(e);
    else q4.push_back(e);
  endtask

  task automatic wr(input int dut, input logic [15:0] off, input logic [31:0] d);
    do_req(dut, 1'b1, {BASE[31:16], off}, d, 4'b1111);
  endtask

  task automatic rd(input int dut, input logic [31:0] addr, input logic rs,
                    input logic [31:0] d, input string name);
    do_req(dut, 1'b0, addr, 32'h0, 4'h0);
    push_rd(dut, name, rs, d);
  endtask

  // mtime with no writes since reset: one count per PRESCALE edges since release.
  task automatic rd_mtime(input int dut, input string name);
    logic [31:0] e;
    do_req(dut, 1'b0, {BASE[31:16], 16'hbff8}, 32'h0, 4'h0);
    e = (dut == 1) ? 32'(edge_cnt) : 32'(edge_cnt / 4);
    push_rd(dut, name, 1'b1, e);
  endtask

  // Check irq at the next monitor sample.
  task automatic exp_irq(input int dut, input logic v, input string name);
    irq_t i;
    i.at   = cyc + 1;
    i.dut  = dut;
    i.name = name;
    i.val  = v;
    qi.push_back(i);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rstn = 1'b1;

    // Free-running mtime and reset contents.
    while (edge_cnt < 9) idle(1);
    rd_mtime(1, "mtime_lo_c10");
    exp_irq(1, 1'b0, "irq_after_rst");
    rd(1, BASE | 32'hbffc, 1'b1, 32'h0, "mtime_hi_rst");
    rd(1, BASE | 32'h4004, 1'b1, 32'hFFFF_FFFF, "cmp_hi_rst");
    exp_irq(4, 1'b0, "irq4_after_rst");
    rd(1, BASE | 32'h4000, 1'b1, 32'hFFFF_FFFF, "cmp_lo_rst");

    // hi=0 then lo=5: masked while LO_PEND, then hi write arms it.
    wr(1, 16'hbff8, 32'd100);
    wr(1, 16'h4004, 32'h0);
    exp_irq(1, 1'b0, "irq_cmp_hi0");
    wr(1, 16'h4000, 32'd5);
    exp_irq(1, 1'b0, "irq_lo_wr");
    idle(1);
    exp_irq(1, 1'b0, "irq_lo_pend_a");
    idle(1);
    exp_irq(1, 1'b0, "irq_lo_pend_b");
    rd(1, BASE | 32'h4000, 1'b1, 32'd5, "cmp_lo_pend");
    wr(1, 16'h4004, 32'h0);
    exp_irq(1, 1'b0, "irq_hi_wr_n1");
    idle(1);
    exp_irq(1, 1'b1, "irq_hi_wr_n2");

    // Partial-mask write is ignored; unmapped and out-of-window reads.
    do_req(1, 1'b1, BASE | 32'h4000, 32'hFFFF_FFFF, 4'b0011);
    exp_irq(1, 1'b1, "irq_mask_a");
    idle(1);
    exp_irq(1, 1'b1, "irq_mask_b");
    rd(1, BASE | 32'h4000, 1'b1, 32'd5, "cmp_lo_masked");
    rd(1, BASE | 32'h4008, 1'b1, 32'h0, "unmapped_4008");
    rd(1, 32'h4401_bff8, 1'b0, 32'h0, "out_of_window");

    // lo then hi raising mtimecmp: irq falls and stays low.
    wr(1, 16'h4000, 32'hFFFF_FFFF);
    exp_irq(1, 1'b1, "irq_raise_lo");
    wr(1, 16'h4004, 32'hFFFF_FFFF);
    exp_irq(1, 1'b0, "irq_raise_hi_a");
    idle(1);
    exp_irq(1, 1'b0, "irq_raise_hi_b");
    idle(1);
    exp_irq(1, 1'b0, "irq_raise_hi_c");

    // Reset while in LO_PEND with irq high.
    wr(1, 16'h4000, 32'h0);
    wr(1, 16'h4004, 32'h0);
    idle(1);
    exp_irq(1, 1'b1, "irq_cmp_zero");
    wr(1, 16'h4000, 32'h0);
    exp_irq(1, 1'b1, "irq_pre_rst");
    idle(1);
    #2;
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;

    // LO_PEND was discarded: mtime at all-ones fires irq, then wraps to 0.
    exp_irq(1, 1'b0, "irq_post_rst_a");
    idle(1);
    exp_irq(1, 1'b0, "irq_post_rst_b");
    wr(1, 16'hbffc, 32'hFFFF_FFFF);
    wr(1, 16'hbff8, 32'hFFFF_FFFF);
    rd(1, BASE | 32'hbff8, 1'b1, 32'hFFFF_FFFF, "mtime_all_ones");
    exp_irq(1, 1'b1, "irq_mtime_max");
    rd(1, BASE | 32'hbffc, 1'b1, 32'h0, "mtime_wrap_hi");
    exp_irq(1, 1'b0, "irq_mtime_wrapped");
    rd(1, BASE | 32'hbff8, 1'b1, 32'h1, "mtime_wrap_lo");
    rd(1, BASE | 32'h4004, 1'b1, 32'hFFFF_FFFF, "cmp_hi_post_rst");
    idle(2);
    exp_irq(1, 1'b0, "irq_no_rewrite");
    wr(1, 16'h4000, 32'h0);
    wr(1, 16'h4004, 32'h0);
    idle(1);
    exp_irq(1, 1'b1, "irq_rewritten");

    // PRESCALE=4: one count per four cycles, tick-cycle write, carry on next tick.
    while (edge_cnt % 4 != 0) idle(1);
    rd_mtime(4, "p4_mtime_0");
    rd_mtime(4, "p4_mtime_1");
    rd_mtime(4, "p4_mtime_2");
    rd_mtime(4, "p4_mtime_3");
    rd_mtime(4, "p4_mtime_4");
    while (edge_cnt % 4 != 2) idle(1);
    wr(4, 16'hbff8, 32'hFFFF_FFFF);
    rd(4, BASE | 32'hbff8, 1'b1, 32'hFFFF_FFFF, "p4_lo_written");
    rd(4, BASE | 32'hbffc, 1'b1, 32'h0, "p4_hi_no_carry");
    idle(1);
    rd(4, BASE | 32'hbff8, 1'b1, 32'hFFFF_FFFF, "p4_lo_before_tick");
    rd(4, BASE | 32'hbffc, 1'b1, 32'h1, "p4_hi_carry");
    rd(4, BASE | 32'hbff8, 1'b1, 32'h0, "p4_lo_carry");
    exp_irq(4, 1'b0, "irq4_end");
    idle(3);
    finish_req = 1'b1;
  end

endmodule
